// File: rtl/omem_reader_if.sv
// -----------------------------------------------------------------------------
// omem_reader_if
//   Bundles the signals between omem_reader and the logic around it: the
//   start/status handshake, the read port of the output memory, and the
//   valid/ready word stream.
//
//   master modport (used by omem_reader):
//     in  : start, mem_data[8:0], out_ready
//     out : busy, done, mem_bank[6:0], mem_rd, out_valid, out_data[8:0],
//           out_index[6:0]
//   slave modport: the same signals with the directions reversed.
// -----------------------------------------------------------------------------
interface omem_reader_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [6:0] mem_bank;
    logic       mem_rd;
    logic [8:0] mem_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [6:0] out_index;

    modport master (
        input  start, mem_data, out_ready,
        output busy, done, mem_bank, mem_rd, out_valid, out_data, out_index
    );

    modport slave (
        output start, mem_data, out_ready,
        input  busy, done, mem_bank, mem_rd, out_valid, out_data, out_index
    );
endinterface

// File: rtl/omem_reader.sv
// -----------------------------------------------------------------------------
// omem_reader
//   Drain sequencer for the output memory (single port, one-cycle registered
//   read). A start pulse in IDLE walks banks 0..DEPTH-1, issuing one read per
//   bank. Each returned word goes through a 2-entry FIFO and is streamed out
//   on a valid/ready interface, tagged with the bank it came from.
//
//   Parameters : DEPTH - number of banks to drain (1..128)
//   Ports      : clock - rising-edge clock
//                reset - synchronous, active-high reset
//                bus   - omem_reader_if.master (start/busy/done, memory read
//                        port, out_valid/out_ready/out_data/out_index)
//
//   Build option: define OMEM_READER_CLIP_EN to clamp negative words.
//   The word is treated as signed 9-bit, and out_data reads 0 when bit 8 is
//   set. The stored word and out_index are not affected.
// -----------------------------------------------------------------------------
module omem_reader #(
    parameter int DEPTH = 75
) (
    input  logic          clock,
    input  logic          reset,
    omem_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // The address counter is one bit wider than the bank address.
    // This lets it reach DEPTH == 128 without wrapping.
    localparam logic [7:0] DEPTH_W = 8'(DEPTH);
    localparam logic [7:0] LAST_W  = 8'(DEPTH - 1);

    state_t     state_reg, state_next;
    logic [7:0] addr_reg, addr_next;
    logic [6:0] bank_reg;
    logic       inflight_reg;
    logic [1:0] count_reg;
    logic       rd_ptr_reg, wr_ptr_reg;

    logic       issue;
    logic       done_w;
    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic [6:0] mem_bank_w;
    logic [8:0] head_data;
    logic [6:0] head_index;

    assign push = inflight_reg;
    assign pop  = (count_reg != 2'd0) && bus.out_ready;

    // This is the occupancy the buffer will have if one more read issues now.
    // It counts the word still in flight and takes a same-cycle pop into
    // account. pop only happens when count_reg is nonzero, so the subtraction
    // cannot underflow.
    assign occupancy = {1'b0, count_reg} - {2'b00, pop} + {2'b00, inflight_reg};

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        issue      = 1'b0;
        done_w     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    addr_next  = 8'd0;
                end
            end
            RUN: begin
                if (addr_reg < DEPTH_W && occupancy < 3'd2) begin
                    issue     = 1'b1;
                    addr_next = addr_reg + 8'd1;
                    if (addr_reg == LAST_W) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_reg && count_reg == 2'd0) begin
                    state_next = IDLE;
                    done_w     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_bank keeps its last issued value between reads. Because of this,
    // bank_reg is also the bank of the word that is currently in flight.
    assign mem_bank_w = issue ? addr_reg[6:0] : bank_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= 8'd0;
            bank_reg     <= 7'd0;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            bank_reg     <= mem_bank_w;
            inflight_reg <= issue;
            count_reg    <= count_reg + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Two FIFO slots, each holding {index, data}. The issue rule keeps a push
    // from ever landing on a full buffer, so no overflow guard is needed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [8:0] data_reg;
        logic [6:0] index_reg;

        always_ff @(posedge clock) begin
            if (reset) begin
                data_reg  <= 9'd0;
                index_reg <= 7'd0;
            end else if (push && wr_ptr_reg == 1'(gi)) begin
                data_reg  <= bus.mem_data;
                index_reg <= bank_reg;
            end
        end
    end

    assign head_data  = rd_ptr_reg ? g_entry[1].data_reg  : g_entry[0].data_reg;
    assign head_index = rd_ptr_reg ? g_entry[1].index_reg : g_entry[0].index_reg;

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_w;
    assign bus.mem_rd    = issue;
    assign bus.mem_bank  = mem_bank_w;
    assign bus.out_valid = (count_reg != 2'd0);
    assign bus.out_index = head_index;
`ifdef OMEM_READER_CLIP_EN
    assign bus.out_data  = head_data[8] ? 9'd0 : head_data;
`else
    assign bus.out_data  = head_data;
`endif

endmodule
